// File: rtl/joypad_ctrl_pkg.sv
// Shared constants and helpers for the joypad controller.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package joypad_ctrl_pkg;

  // Default geometry: a direction group and an action group of four lines each.
  localparam int DEFAULT_NUM_GROUPS      = 2;
  localparam int DEFAULT_LINES_PER_GROUP = 4;

  // Button lines are active-low.
  localparam logic PRESSED  = 1'b0;
  localparam logic RELEASED = 1'b1;

  // Counter width for a count range of 0..value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/joypad_ctrl_if.sv
// Button pins, CPU select/ack strobes and the P1-style read/irq outputs.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is level or single-cycle strobe.
interface joypad_ctrl_if #(
  parameter int NUM_GROUPS      = joypad_ctrl_pkg::DEFAULT_NUM_GROUPS,
  parameter int LINES_PER_GROUP = joypad_ctrl_pkg::DEFAULT_LINES_PER_GROUP
);
  logic [NUM_GROUPS*LINES_PER_GROUP-1:0] iButtons;
  logic                                  iSelectWe;
  logic [NUM_GROUPS-1:0]                 iSelect;
  logic                                  iIrqAck;
  logic [NUM_GROUPS+LINES_PER_GROUP-1:0] oP;
  logic                                  oIrq;

  // Board/CPU side drives pins and strobes and observes the read value.
  modport master (
    output iButtons, iSelectWe, iSelect, iIrqAck,
    input  oP, oIrq
  );

  // Controller side.
  modport slave (
    input  iButtons, iSelectWe, iSelect, iIrqAck,
    output oP, oIrq
  );
endinterface

// File: rtl/joypad_debounce_cell.sv
// One button: synchroniser chain, stability counter and accepted-level flop.
// Latency: a held raw change reaches stable after SYNC_STAGES+DEBOUNCE_CYCLES edges.
// Backpressure: none; the raw pin is sampled every cycle.
module joypad_debounce_cell
  import joypad_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw_n,
  output logic stable
);

  localparam int             CW       = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   s;

  // Shift the asynchronous pin through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_n};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Accept a new level only after it has differed from the stable one for a
  // full run of consecutive cycles; any return to the stable level restarts.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers; reset looks like a released button with no partial count.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_q   <= {SYNC_STAGES{RELEASED}};
      cnt_q    <= '0;
      stable_q <= RELEASED;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/joypad_ctrl.sv
// Joypad controller: debounced buttons muxed by active-low group selects, sticky irq.
// Latency: pin->oP SYNC_STAGES+DEBOUNCE_CYCLES edges; select->oP same edge; oIrq one edge after oP falls.
// Backpressure: none; select writes and acks take effect on the edge they are presented.
module joypad_ctrl
  import joypad_ctrl_pkg::*;
#(
  parameter int NUM_GROUPS      = DEFAULT_NUM_GROUPS,
  parameter int LINES_PER_GROUP = DEFAULT_LINES_PER_GROUP,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic          Clock,
  input  logic          Reset,
  joypad_ctrl_if.slave  bus
);

  localparam int NB = NUM_GROUPS * LINES_PER_GROUP;

  logic [NB-1:0]              stable;
  logic [NUM_GROUPS-1:0]      sel_q, sel_d;
  logic [LINES_PER_GROUP-1:0] prev_q, prev_d;
  logic                       irq_q, irq_d;
  logic [LINES_PER_GROUP-1:0] line;
  logic                       fall;

  for (genvar i = 0; i < NB; i++) begin : g_cell
    joypad_debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .Clock  (Clock),
      .Reset  (Reset),
      .raw_n  (bus.iButtons[i]),
      .stable (stable[i])
    );
  end

  // Wire-AND the enabled groups line by line; a group is enabled when its select bit is 0.
  always_comb begin
    line = {LINES_PER_GROUP{RELEASED}};
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (sel_q[g] == 1'b0) begin
        for (int j = 0; j < LINES_PER_GROUP; j++) begin
          line[j] = line[j] & stable[g*LINES_PER_GROUP + j];
        end
      end
    end
  end

  // Select load, falling-line detect and sticky irq; a new fall beats a same-cycle ack.
  always_comb begin
    sel_d  = bus.iSelectWe ? bus.iSelect : sel_q;
    prev_d = line;
    fall   = |(prev_q & ~line);
    irq_d  = fall | (irq_q & ~bus.iIrqAck);
  end

  // Control registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sel_q  <= '1;
      prev_q <= {LINES_PER_GROUP{RELEASED}};
      irq_q  <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      prev_q <= prev_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.oP   = {sel_q, line};
  assign bus.oIrq = irq_q;

endmodule

// File: doc/joypad_ctrl.md
Name: joypad_ctrl

Overview:
Parametrised joypad controller and successor of the fixed 6-bit P1 block. It samples raw active-low button lines and debounces each one. It multiplexes NUM_GROUPS groups of LINES_PER_GROUP lines onto a P1-style read value under CPU-written active-low group selects. It raises a sticky joypad interrupt request on any selected line's high-to-low transition, cleared by acknowledge. It sits between the board button pins and the CPU I/O register / interrupt controller.

Parameters:
NUM_GROUPS, 2, number of button groups (direction, action); >=1
LINES_PER_GROUP, 4, lines per group returned on the read value; >=1
DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to accept a new button level; >=1
SYNC_STAGES, 2, synchroniser depth on raw inputs; >=2

Ports:
Clock  input  1  system clock; all state on rising edge
Reset  input  1  asynchronous, active-high reset
iButtons  input  NUM_GROUPS*LINES_PER_GROUP  raw buttons, active-low (0 = pressed); bit g*LINES_PER_GROUP+j = group g, line j; asynchronous to Clock
iSelectWe  input  1  write strobe for select register
iSelect  input  NUM_GROUPS  select write data, active-low (0 = group enabled)
iIrqAck  input  1  one-cycle interrupt acknowledge
oP  output  NUM_GROUPS+LINES_PER_GROUP  read value {select register, line vector}
oIrq  output  1  sticky joypad interrupt request, active-high

Behaviour:
- Reset: clock and reset are fixed as one clock, Clock, with asynchronous active-high Reset. Reset asynchronously sets sync flops to all 1, stable levels to all 1 (released), debounce counters to 0, select register to all 1, previous-line register to all 1, and oIrq to 0. oP = all 1 during and after reset.
- Synchroniser: each button passes through a SYNC_STAGES flop chain; output s[i].
- Debounce, per button i, each edge:
  - if s[i]==stable[i]: cnt[i]<=0
  - else if cnt[i]==DEBOUNCE_CYCLES-1: stable[i]<=s[i], cnt[i]<=0
  - else: cnt[i]<=cnt[i]+1
  - Counter width is clog2(DEBOUNCE_CYCLES), minimum 1 bit. The counter never wraps.
  - Any bounce back to the stable level restarts the count.
- Latency: a raw change held steady updates stable after exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges.
- Select register: loaded from iSelect on an edge with iSelectWe=1; otherwise it holds.
- Line vector, combinational from registers: line[j] = AND of stable[g*L+j] over all g with sel[g]==0. If no group is selected, line = all 1. Multiple selected groups wire-AND (press in either group reads 0).
- oP = {sel, line}. There is no extra latency beyond the register outputs.
- Interrupt:
  - prev <= line every edge.
  - fall = |(prev & ~line).
  - oIrq <= fall | (oIrq & ~iIrqAck). When fall and iIrqAck occur together, oIrq stays 1.
  - oIrq rises one edge after the falling line appears on oP.
  - A falling line caused by a select write also requests an interrupt.
  - Rising lines (release) never request.
- Reset mid-debounce discards partial counts. After reset release, a held button needs a full SYNC_STAGES+DEBOUNCE_CYCLES before it is seen.
- No X propagation: there is no default branch emitting unknowns, and no simulation-only messages in the datapath.

Decomposition:
- Shared include (alongside the existing collateral primitives) holds:
  - the default group/line counts
  - active-low level constants (PRESSED=0, RELEASED=1)
  - the clog2 macro
- One natural sub-module, joypad_debounce_cell: synchroniser chain, counter and stable flop for one button, with parameters SYNC_STAGES and DEBOUNCE_CYCLES.
- The top instantiates NUM_GROUPS*LINES_PER_GROUP cells via generate. The select register, line mux and irq logic stay in the top.

Test Plan:
Use G=2, L=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
1. Reset, then no activity for 10 cycles -> oP=6'b111111, oIrq=0.
2. Write iSelect=2'b10, then drive iButtons=8'b11111110 held -> oP=6'b101110 exactly 6 edges after the input change; oIrq=1 on the next edge; pulse iIrqAck -> oIrq=0 on the following edge.
3. Select 2'b10, toggle iButtons[0] every 3 cycles for 30 cycles -> oP stays 6'b101111, oIrq stays 0.
4. Write select 2'b00, hold iButtons=8'b11101101 (group1 line0, group0 line1) -> oP=6'b001100 after debounce; oIrq asserted.
5. Select 2'b11, press iButtons[2] -> oP=6'b111111, oIrq=0. Then write select 2'b10 -> oP=6'b101011 the same cycle the register updates, and oIrq=1 one edge later.
6. Assert iIrqAck on the same edge that a new line falls -> oIrq remains 1. Separately, assert Reset 2 cycles into a debounce count, then release with the button still held -> oP falls only 6 edges after reset release.
